rect_fill_engine: RTL and testbench
===================================

# rect_fill_engine

Rectangle rasteriser between the game FSM and `vga_adapter`. The FSM pushes filled-rectangle commands (paddle, ball, blocks, full-screen clears) through a valid/ready port into a small command FIFO. The engine pops commands and emits one pixel write per clock, row-major, on `x`/`y`/`colour`/`plot`. These outputs drive `vga_adapter` directly, so the FSM no longer sequences pixels itself and `plot` is no longer tied high.

## Interface
- `FIFO_DEPTH`, 4: command FIFO entries (power of two, ≥2).
- `SCREEN_W`, 160: pixels with x ≥ SCREEN_W are suppressed.
- `SCREEN_H`, 120: pixels with y ≥ SCREEN_H are suppressed.
- `clock`  in  1  system clock (CLOCK_50); single clock domain.
- `resetn`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO not full; combinational from FIFO count.
- `cmd_x`  in  8  left column.
- `cmd_y`  in  8  top row.
- `cmd_w`  in  8  width in pixels; 0 means no-op.
- `cmd_h`  in  8  height in pixels; 0 means no-op.
- `cmd_colour`  in  3  RGB colour, 1 bit per channel.
- `x`  out  8  pixel column to `vga_adapter`.
- `y`  out  7  pixel row to `vga_adapter`.
- `colour`  out  3  pixel colour.
- `plot`  out  1  write strobe; high for exactly one cycle per on-screen pixel.
- `busy`  out  1  FIFO non-empty or state ≠ IDLE.

## Operation
- Push: `cmd_valid && cmd_ready` at a rising edge writes {x,y,w,h,colour} at the FIFO tail.
  - `cmd_valid` while full is ignored; the producer must hold the command.
- Simultaneous push and pop: count unchanged, both take effect. Pointers wrap modulo FIFO_DEPTH.
- States:
  - IDLE: `plot`=0. If the FIFO is non-empty, pop the head into working registers (x0, y0, w, h, colour), clear col/row counters, go to SCAN. If w==0 or h==0, go to SKIP instead.
  - SCAN: each edge, register `x`=x0+col and `y`=(y0+row)[6:0], and set `colour`.
    - `plot`=1 only if x0+col < SCREEN_W and y0+row < SCREEN_H; off-screen pixels still take a cycle with `plot`=0.
    - col increments; when col==w-1, col←0 and row increments.
    - After pixel (w-1,h-1), go to IDLE.
  - SKIP: one cycle with `plot`=0, then IDLE.
- Arithmetic: x0+col and y0+row are computed 9 bits wide. There is no wrap; overflow past 255 counts as off-screen. col and row are 8-bit.
- Pixel order is row-major: (x0,y0), (x0+1,y0) … (x0+w-1,y0+h-1).
- `colour` is latched at pop; later pushes never alter an in-flight rectangle.
- Reset (asynchronous, any time including mid-rectangle):
  - FIFO emptied; state IDLE.
  - `x`=0, `y`=0, `colour`=0, `plot`=0, `busy`=0, `cmd_ready`=1.
  - The in-flight rectangle is abandoned, not resumed.

## Timing
- Command accepted at edge E0 into an empty FIFO with the engine in IDLE:
  - E1: pop, state→SCAN, `plot`=0.
  - E2: first pixel registered, `plot`=1.
  - Last pixel at E2+w·h−1.
  - Following edge: `plot`=0 and the next pop, if any.
- Throughput: one pixel per clock within a rectangle, plus one bubble cycle between rectangles.
- A zero-size command costs two cycles (pop, SKIP) with no plot.
- `busy` falls at the edge where IDLE is re-entered with the FIFO empty.
- `cmd_ready` is combinational; it falls in the same cycle the count reaches FIFO_DEPTH and rises the cycle after a pop from full.
- All outputs except `cmd_ready` are registered; no combinational path from `cmd_*` to `x`/`y`/`plot`.
- Full-screen clear (0,0,160,120): 19200 pixel cycles, about 0.38 ms, well within one 60 Hz frame.

## Test plan
- Paddle: push (76,110,16,2,111) at E0 → `plot` high E2..E33 (32 cycles); first (76,110), 16th (91,110), last (91,111); `colour`=111 throughout; `busy` low at E34.
- Clipping: push (155,118,8,4,010) → 32 SCAN cycles; `plot`=1 for exactly 10 of them (x 155..159, y 118..119); no plot with x≥160 or y≥120.
- Full FIFO:
  - Push a 10×10 at E0, then four 1×1 commands at E1..E4 → all accepted; `cmd_ready`=0 from E4.
  - A sixth command held valid is accepted only after the 10×10 finishes and the next pop frees a slot.
  - All five rectangles are drawn in push order.
- Zero size: push (20,20,0,5,111) → no `plot` pulse; `busy` 1 at E1, 0 at E3; next command behaves normally.
- Back-to-back: push (0,0,2,1,001) and (4,0,2,1,100) on consecutive edges → `plot` sequence 1,1,0,1,1 with `x`=0,1,–,4,5.
- Reset mid-operation: assert `resetn` low during the 5th pixel of an 8×8 with two queued commands → `plot`=0 and `busy`=0 immediately, without a clock. After release, `cmd_ready`=1 and no queued pixels appear; a new 1×1 plots 2 cycles after acceptance.

Source files
------------

// File: rtl/rect_fill_engine.sv
// Rectangle rasteriser: queues fill commands and streams one pixel write per clock, row-major.
// Latency: pop one edge after accept, first pixel one edge after pop; one idle bubble between rectangles.
// Backpressure: cmd_ready follows the command FIFO count combinationally; a held command waits for a free slot.
//
// Ports: clock/resetn (async active-low); cmd_valid/cmd_ready with cmd_x/y/w/h/colour;
//        x/y/colour/plot pixel write to vga_adapter; busy while work is queued or in flight.

// Small generic synchronous FIFO used for the command queue.
// Latency: a pushed entry is at the head the cycle after the push.
// Backpressure: push_rdy is low while the entry count equals DEPTH.
module rect_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         push_vld,
    output logic         push_rdy,
    input  logic [W-1:0] push_dat,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign push_rdy = (count != FULL_CNT);
    assign pop_vld  = (count != '0);
    assign pop_dat  = mem[rd_ptr];
    assign do_push  = push_vld && push_rdy;
    assign do_pop   = pop_vld && pop_rdy;

    // Storage needs no reset; only the pointers and count define validity.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

module rect_fill_engine #(
    parameter int FIFO_DEPTH = 4,
    parameter int SCREEN_W   = 160,
    parameter int SCREEN_H   = 120
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_x,
    input  logic [7:0] cmd_y,
    input  logic [7:0] cmd_w,
    input  logic [7:0] cmd_h,
    input  logic [2:0] cmd_colour,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy
);
    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] w;
        logic [7:0] h;
        logic [2:0] colour;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, SCAN, SKIP} state_t;

    localparam logic [8:0] SCR_W = 9'(SCREEN_W);
    localparam logic [8:0] SCR_H = 9'(SCREEN_H);

    cmd_t   push_cmd;
    cmd_t   head;
    logic   fifo_vld;
    logic   fifo_pop;
    state_t state;
    state_t state_nxt;

    logic [7:0] rect_x0;
    logic [7:0] rect_y0;
    logic [7:0] rect_w;
    logic [7:0] rect_h;
    logic [2:0] rect_colour;
    logic [7:0] col;
    logic [7:0] row;
    logic [8:0] sx;
    logic [8:0] sy;
    logic       on_screen;
    logic       col_last;
    logic       row_last;

    assign push_cmd = '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, colour: cmd_colour};

    rect_fifo #(
        .W     ($bits(cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clock    (clock),
        .resetn   (resetn),
        .push_vld (cmd_valid),
        .push_rdy (cmd_ready),
        .push_dat (push_cmd),
        .pop_vld  (fifo_vld),
        .pop_rdy  (fifo_pop),
        .pop_dat  (head)
    );

    // 9-bit sums: anything past 255 lands beyond the screen instead of wrapping to the left edge.
    assign sx        = {1'b0, rect_x0} + {1'b0, col};
    assign sy        = {1'b0, rect_y0} + {1'b0, row};
    assign on_screen = (sx < SCR_W) && (sy < SCR_H);
    assign col_last  = (col == rect_w - 8'd1);
    assign row_last  = (row == rect_h - 8'd1);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_vld) begin
                    fifo_pop  = 1'b1;
                    state_nxt = (head.w == 8'd0 || head.h == 8'd0) ? SKIP : SCAN;
                end
            end
            SCAN: begin
                if (col_last && row_last) begin
                    state_nxt = IDLE;
                end
            end
            SKIP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rect_x0     <= '0;
            rect_y0     <= '0;
            rect_w      <= '0;
            rect_h      <= '0;
            rect_colour <= '0;
            col         <= '0;
            row         <= '0;
            x           <= '0;
            y           <= '0;
            colour      <= '0;
            plot        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // Registered from the current state, so it drops one edge after the last pixel.
            busy <= fifo_vld || (state != IDLE);
            plot <= 1'b0;
            if (fifo_pop) begin
                rect_x0     <= head.x;
                rect_y0     <= head.y;
                rect_w      <= head.w;
                rect_h      <= head.h;
                rect_colour <= head.colour;
                col         <= '0;
                row         <= '0;
            end
            if (state == SCAN) begin
                x      <= sx[7:0];
                y      <= sy[6:0];
                colour <= rect_colour;
                plot   <= on_screen;
                if (col_last) begin
                    col <= '0;
                    row <= row + 8'd1;
                end else begin
                    col <= col + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_rect_fill_engine.sv
module tb_rect_fill_engine;
    logic       clock;
    logic       resetn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_x;
    logic [7:0] cmd_y;
    logic [7:0] cmd_w;
    logic [7:0] cmd_h;
    logic [2:0] cmd_colour;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;

    rect_fill_engine #(
        .FIFO_DEPTH (4),
        .SCREEN_W   (160),
        .SCREEN_H   (120)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_w      (cmd_w),
        .cmd_h      (cmd_h),
        .cmd_colour (cmd_colour),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] w;
        logic [7:0] h;
        logic [2:0] c;
        int n_plot;
        int fx, fy, lx, ly;
        int mid_idx, mx, my;
        int busy_fall;
    } vec_t;

    int nerr = 0;
    int nchk = 0;

    // Results of the latest run_cmd
    int r_np, r_fe, r_fx, r_fy, r_lx, r_ly, r_mx, r_my, r_bfall, r_cerr, r_oerr, r_busy1;

    task automatic chk(input string name, input integer act, input integer exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_cmd(input int cx, input int cy, input int cw, input int ch, input int cc);
        cmd_x      = 8'(cx);
        cmd_y      = 8'(cy);
        cmd_w      = 8'(cw);
        cmd_h      = 8'(ch);
        cmd_colour = 3'(cc);
        cmd_valid  = 1'b1;
    endtask

    // Push one command into an idle engine and watch it until busy falls.
    // Edge indices count from the accepting edge E0.
    task automatic run_cmd(input vec_t v);
        set_cmd(v.x, v.y, v.w, v.h, v.c);
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        r_np = 0; r_fe = -1; r_fx = -1; r_fy = -1; r_lx = -1; r_ly = -1;
        r_mx = -1; r_my = -1; r_bfall = -1; r_cerr = 0; r_oerr = 0; r_busy1 = -1;
        for (int e = 1; e <= 400 && r_bfall < 0; e++) begin
            @(posedge clock); #1;
            if (e == 1) r_busy1 = busy;
            if (plot) begin
                if (r_np == 0) begin
                    r_fe = e; r_fx = x; r_fy = y;
                end
                if (r_np == v.mid_idx) begin
                    r_mx = x; r_my = y;
                end
                r_lx = x; r_ly = y;
                if (colour != v.c) r_cerr++;
                if (x >= 160 || y >= 120) r_oerr++;
                r_np++;
            end
            if (!busy) r_bfall = e;
        end
    endtask

    vec_t tbl[10];
    vec_t v1;
    int   px[$];
    int   py[$];
    int   pc[$];
    int   exp_p[5] = '{1, 1, 0, 1, 1};
    int   exp_x[5] = '{0, 1, 0, 4, 5};
    int   exp_c[5] = '{1, 1, 0, 4, 4};
    int   acc, acc6, bfall, np;
    logic wa;

    initial begin
        //           x    y    w   h  c  np  fx   fy   lx   ly  mid  mx   my  bfall
        tbl[0] = '{ 76, 110, 16,  2, 7, 32, 76, 110,  91, 111, 15,  91, 110, 34};
        tbl[1] = '{155, 118,  8,  4, 2, 10, 155, 118, 159, 119,  5, 155, 119, 34};
        tbl[2] = '{  3,   4,  1,  1, 5,  1,  3,   4,   3,   4,  0,   3,   4,  3};
        tbl[3] = '{250,  10, 10,  1, 3,  0,  0,   0,   0,   0, -1,   0,   0, 12};
        tbl[4] = '{  0,   0,  3,  2, 1,  6,  0,   0,   2,   1,  3,   0,   1,  8};
        tbl[5] = '{ 10, 200,  2,  2, 4,  0,  0,   0,   0,   0, -1,   0,   0,  6};
        tbl[6] = '{ 20,  20,  0,  5, 7,  0,  0,   0,   0,   0, -1,   0,   0,  3};
        tbl[7] = '{159, 119,  1,  1, 6,  1, 159, 119, 159, 119,  0, 159, 119,  3};
        tbl[8] = '{100,   5,  3,  0, 2,  0,  0,   0,   0,   0, -1,   0,   0,  3};
        tbl[9] = '{  0, 119,  1,  2, 7,  1,  0, 119,   0, 119,  0,   0, 119,  4};

        resetn = 1'b0;
        cmd_valid = 1'b0;
        cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_colour = '0;

        // Reset state
        #15;
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_colour", colour, 0);
        chk("rst_plot", plot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        #20 resetn = 1'b1;

        // Table of single rectangles
        for (int i = 0; i < 10; i++) begin
            run_cmd(tbl[i]);
            chk($sformatf("v%0d_plots", i), r_np, tbl[i].n_plot);
            chk($sformatf("v%0d_busy_e1", i), r_busy1, 1);
            chk($sformatf("v%0d_busy_fall", i), r_bfall, tbl[i].busy_fall);
            chk($sformatf("v%0d_colour_errs", i), r_cerr, 0);
            chk($sformatf("v%0d_offscreen", i), r_oerr, 0);
            if (tbl[i].n_plot > 0) begin
                chk($sformatf("v%0d_first_edge", i), r_fe, 2);
                chk($sformatf("v%0d_first_x", i), r_fx, tbl[i].fx);
                chk($sformatf("v%0d_first_y", i), r_fy, tbl[i].fy);
                chk($sformatf("v%0d_last_x", i), r_lx, tbl[i].lx);
                chk($sformatf("v%0d_last_y", i), r_ly, tbl[i].ly);
                chk($sformatf("v%0d_mid_x", i), r_mx, tbl[i].mx);
                chk($sformatf("v%0d_mid_y", i), r_my, tbl[i].my);
            end
        end

        // Back-to-back: two 2x1 rectangles on consecutive edges
        set_cmd(0, 0, 2, 1, 1);
        @(posedge clock); #1;
        set_cmd(4, 0, 2, 1, 4);
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        for (int e = 0; e < 5; e++) begin
            @(posedge clock); #1;
            chk($sformatf("b2b_plot_e%0d", e + 2), plot, exp_p[e]);
            if (exp_p[e] == 1) begin
                chk($sformatf("b2b_x_e%0d", e + 2), x, exp_x[e]);
                chk($sformatf("b2b_colour_e%0d", e + 2), colour, exp_c[e]);
            end
        end
        repeat (3) @(posedge clock);
        #1;

        // Full FIFO: 10x10, four 1x1s, then a sixth held until a slot frees
        px.delete(); py.delete(); pc.delete();
        set_cmd(0, 0, 10, 10, 1);
        acc = 0; acc6 = -1; bfall = -1;
        for (int e = 0; e <= 400 && bfall < 0; e++) begin
            wa = cmd_valid && cmd_ready;
            @(posedge clock); #1;
            if (wa) begin
                acc++;
                if (e >= 5 && acc6 < 0) acc6 = e;
            end
            if (e == 3) chk("full_ready_before_e4", cmd_ready, 1);
            if (e == 4) chk("full_ready_low_e4", cmd_ready, 0);
            if (plot) begin
                px.push_back(int'(x));
                py.push_back(int'(y));
                pc.push_back(int'(colour));
            end
            if (e < 4) begin
                set_cmd(20 + e, 30, 1, 1, e + 2);
            end else if (e == 4) begin
                set_cmd(50, 50, 1, 1, 7);
            end else if (wa) begin
                cmd_valid = 1'b0;
            end
            if (e > 5 && !busy) bfall = e;
        end
        cmd_valid = 1'b0;
        np = px.size();
        chk("full_accepts", acc, 6);
        chk("full_sixth_accept_edge", acc6, 103);
        chk("full_busy_fall", bfall, 112);
        chk("full_plots", np, 105);
        if (np == 105) begin
            chk("full_first_x", px[0], 0);
            chk("full_first_y", py[0], 0);
            chk("full_big_last_x", px[99], 9);
            chk("full_big_last_y", py[99], 9);
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("full_small%0d_x", k), px[100 + k], 20 + k);
                chk($sformatf("full_small%0d_y", k), py[100 + k], 30);
                chk($sformatf("full_small%0d_colour", k), pc[100 + k], k + 2);
            end
            chk("full_sixth_x", px[104], 50);
            chk("full_sixth_y", py[104], 50);
            chk("full_sixth_colour", pc[104], 7);
        end

        // Reset during the 5th pixel of an 8x8 with two commands queued
        set_cmd(0, 0, 8, 8, 3);
        @(posedge clock); #1;
        set_cmd(40, 40, 1, 1, 5);
        @(posedge clock); #1;
        set_cmd(41, 41, 1, 1, 6);
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        repeat (4) begin
            @(posedge clock); #1;
        end
        chk("mid_plot_before_reset", plot, 1);
        chk("mid_x_before_reset", x, 4);
        #3 resetn = 1'b0;
        #1;
        chk("mid_rst_plot", plot, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_x", x, 0);
        chk("mid_rst_colour", colour, 0);
        chk("mid_rst_ready", cmd_ready, 1);
        repeat (2) @(posedge clock);
        #5 resetn = 1'b1;
        np = 0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clock); #1;
            if (plot) np++;
        end
        chk("post_rst_no_plots", np, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_ready", cmd_ready, 1);

        v1 = '{7, 7, 1, 1, 5, 1, 7, 7, 7, 7, 0, 7, 7, 3};
        run_cmd(v1);
        chk("post_rst_1x1_plots", r_np, 1);
        chk("post_rst_1x1_edge", r_fe, 2);
        chk("post_rst_1x1_x", r_fx, 7);
        chk("post_rst_1x1_y", r_fy, 7);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
